// File: rtl/rr_arb_pkg.sv
// Shared types, default parameters and the one-hot to index helper for rr_arbiter.
package rr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int unsigned N_REQ_DEF    = 4;
  localparam int unsigned MAX_HOLD_DEF = 16;

  // Sized for the largest supported requester count (16); callers cast down to ID_W.
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_prio_pick.sv
// Rotating-priority pick: rotate req by ptr, take lowest set bit, rotate back and encode.
module rr_prio_pick
  import rr_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] winner,
  output logic [ID_W-1:0]  winner_id,
  output logic             any
);

  logic [N_REQ-1:0] rot;
  logic [N_REQ-1:0] pick;

  always_comb begin
    rot    = '0;
    pick   = '0;
    winner = '0;
    // Bit i of rot is requester (ptr + i) mod N_REQ, so bit 0 has top priority.
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rot[i] = req[(i + int'(ptr)) % N_REQ];
    end
    pick = rot & (~rot + N_REQ'(1));
    for (int unsigned j = 0; j < N_REQ; j++) begin
      winner[j] = pick[(j + N_REQ - int'(ptr)) % N_REQ];
    end
  end

  assign winner_id = ID_W'(onehot_to_idx(16'(winner)));
  assign any       = |req;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with grant lock until release.
// Optional grant-length limit enabled by defining RR_ARB_TIMEOUT_EN.
module rr_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = N_REQ_DEF,
  parameter int unsigned ID_W     = $clog2(N_REQ),
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
    $error("rr_arbiter: N_REQ must be in 2..16");
  end
  if (MAX_HOLD < 2) begin : g_bad_max_hold
    $error("rr_arbiter: MAX_HOLD must be >= 2");
  end

  arb_state_t       state;
  logic [ID_W-1:0]  ptr;
  logic [N_REQ-1:0] pick_oh;
  logic [ID_W-1:0]  pick_id;
  logic             pick_any;
  logic             owner_req;
  logic [ID_W-1:0]  next_ptr;

  rr_prio_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req       (req),
    .ptr       (ptr),
    .winner    (pick_oh),
    .winner_id (pick_id),
    .any       (pick_any)
  );

  assign owner_req = |(req & gnt);
  assign next_ptr  = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

`ifdef RR_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(MAX_HOLD);
  logic [CNT_W-1:0] hold_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            state     <= BUSY;
            gnt       <= pick_oh;
            gnt_id    <= pick_id;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
          end
        end
        BUSY: begin
          // Release takes precedence over expiry on the same edge.
          if (!owner_req || hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= next_ptr;
            timeout   <= owner_req;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign timeout = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state     <= BUSY;
            gnt       <= pick_oh;
            gnt_id    <= pick_id;
            gnt_valid <= 1'b1;
          end
        end
        BUSY: begin
          if (!owner_req) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (N_REQ=4, MAX_HOLD=4); follows RR_ARB_TIMEOUT_EN if defined.
module tb_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  rr_arbiter #(
    .N_REQ    (4),
    .ID_W     (2),
    .MAX_HOLD (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                       input logic ev, input logic eto);
    total++;
    assert (gnt === eg && gnt_id === eid && gnt_valid === ev && timeout === eto)
    else begin
      bad++;
      $error("FAIL %s: got gnt=%b id=%0d valid=%b timeout=%b, want gnt=%b id=%0d valid=%b timeout=%b",
             tag, gnt, gnt_id, gnt_valid, timeout, eg, eid, ev, eto);
    end
  endtask

  initial begin
    logic [3:0] oh;
    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    tick();
    check("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single requester 0, then release; ptr moves to 1.
    rst_n = 1'b1;
    req   = 4'b0001;
    tick();
    check("t1_grant0", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick();
    check("t1_hold0", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    check("t1_release", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Serve requester 1 so ptr becomes 2.
    req = 4'b0010;
    tick();
    check("t3_grant1", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    check("t3_release1", 4'b0000, 2'd1, 1'b0, 1'b0);

    // ptr=2 with req 0101: requester 2 wins over 0.
    req = 4'b0101;
    tick();
    check("t3_grant2", 4'b0100, 2'd2, 1'b1, 1'b0);
    // Non-owner churn is ignored while BUSY.
    req = 4'b0110;
    tick();
    check("t4_churn_a", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b1101;
    tick();
    check("t4_churn_b", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0100;
    tick();
    check("t4_churn_c", 4'b0100, 2'd2, 1'b1, 1'b0);
    // Owner drops while requester 0 is pending: release wins, id holds.
    req = 4'b0001;
    tick();
    check("t3_release2", 4'b0000, 2'd2, 1'b0, 1'b0);
    tick();
    check("t3_grant0_after2", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    check("t3_release0", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Full rotation from reset: order 0,1,2,3,0 with one idle cycle between.
    rst_n = 1'b0;
    tick();
    check("t2_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    req   = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      tick();
      check("t2_grant", oh, 2'(k % 4), 1'b1, 1'b0);
      tick();
      check("t2_hold_a", oh, 2'(k % 4), 1'b1, 1'b0);
      tick();
      check("t2_hold_b", oh, 2'(k % 4), 1'b1, 1'b0);
      req = 4'b1111 & ~oh;
      tick();
      check("t2_idle", 4'b0000, 2'(k % 4), 1'b0, 1'b0);
      req = (k == 4) ? 4'b0000 : 4'b1111;
    end
    tick();
    check("t2_quiet", 4'b0000, 2'd0, 1'b0, 1'b0);

    // ptr=1, requester 3 only: pointer wraps past 3 back to 0 afterwards.
    req = 4'b1000;
    tick();
    check("t6_grant3", 4'b1000, 2'd3, 1'b1, 1'b0);
    rst_n = 1'b0;
    req   = 4'b1001;
    tick();
    check("t6_reset_mid", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    check("t6_grant0_first", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    check("t6_release", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Hold-limit behaviour with requesters 0 and 1 held.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req   = 4'b0011;
    tick();
    check("t5_grant0", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick();
    check("t5_hold2", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick();
    check("t5_hold3", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick();
    check("t5_hold4", 4'b0001, 2'd0, 1'b1, 1'b0);
`ifdef RR_ARB_TIMEOUT_EN
    tick();
    check("t5_revoke", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    check("t5_grant1", 4'b0010, 2'd1, 1'b1, 1'b0);
    // Release exactly on the expiry edge is a normal release.
    req = 4'b0010;
    tick();
    tick();
    tick();
    req = 4'b0000;
    tick();
    check("t5_release_at_expiry", 4'b0000, 2'd1, 1'b0, 1'b0);
`else
    tick();
    check("t5_no_revoke_a", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick();
    check("t5_no_revoke_b", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0010;
    tick();
    check("t5_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    check("t5_grant1", 4'b0010, 2'd1, 1'b1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
